// File: rtl/triangle_scanner.sv
// triangle_scanner: accepts one triangle, computes its bounding box and walks
// every integer point of the box in raster order, querying an external
// point-in-triangle evaluator and streaming point + verdict downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload stable until that transfer,
// and ready may change freely. tri_valid/tri_ready carry triangles in, and
// out_valid/out_ready carry result beats out.
module triangle_scanner #(
  parameter int W  = 12,
  parameter int CW = 2*W+1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tri_valid,
  output logic          tri_ready,
  input  logic [W-1:0]  ax,
  input  logic [W-1:0]  ay,
  input  logic [W-1:0]  bx,
  input  logic [W-1:0]  by,
  input  logic [W-1:0]  cx,
  input  logic [W-1:0]  cy,
  output logic [W-1:0]  q_px,
  output logic [W-1:0]  q_py,
  input  logic          q_inside,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_x,
  output logic [W-1:0]  out_y,
  output logic          out_inside,
  output logic          out_last,
  output logic          done,
  output logic [CW-1:0] inside_count,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BBOX = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
  logic [W-1:0]  ax_d, ay_d, bx_d, by_d, cx_d, cy_d;
  logic [W-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [W-1:0]  xmin_d, xmax_d, ymin_d, ymax_d;
  logic [W-1:0]  cur_x_q, cur_y_q, cur_x_d, cur_y_d;
  logic [CW-1:0] count_q, count_d;

  logic [W-1:0]  bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic          at_last;
  logic          beat_fire;

  // Unsigned min/max of the latched vertices, consumed during BBOX.
  always_comb begin
    bb_xmin = ax_q;
    bb_xmax = ax_q;
    bb_ymin = ay_q;
    bb_ymax = ay_q;
    if (bx_q < bb_xmin) bb_xmin = bx_q;
    if (cx_q < bb_xmin) bb_xmin = cx_q;
    if (bx_q > bb_xmax) bb_xmax = bx_q;
    if (cx_q > bb_xmax) bb_xmax = cx_q;
    if (by_q < bb_ymin) bb_ymin = by_q;
    if (cy_q < bb_ymin) bb_ymin = cy_q;
    if (by_q > bb_ymax) bb_ymax = by_q;
    if (cy_q > bb_ymax) bb_ymax = cy_q;
  end

  // Next-state, scan cursor and handshake outputs.
  always_comb begin
    state_d    = state_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    bx_d       = bx_q;
    by_d       = by_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    count_d    = count_q;
    tri_ready  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_inside = 1'b0;
    done       = 1'b0;
    beat_fire  = 1'b0;
    at_last    = (cur_x_q == xmax_q) && (cur_y_q == ymax_q);

    case (state_q)
      IDLE: begin
        tri_ready = 1'b1;
        if (tri_valid) begin
          ax_d    = ax;
          ay_d    = ay;
          bx_d    = bx;
          by_d    = by;
          cx_d    = cx;
          cy_d    = cy;
          count_d = '0;
          state_d = BBOX;
        end
      end
      BBOX: begin
        xmin_d  = bb_xmin;
        xmax_d  = bb_xmax;
        ymin_d  = bb_ymin;
        ymax_d  = bb_ymax;
        cur_x_d = bb_xmin;
        cur_y_d = bb_ymin;
        state_d = SCAN;
      end
      SCAN: begin
        out_valid  = 1'b1;
        out_last   = at_last;
        out_inside = q_inside;
        beat_fire  = out_ready;
        if (beat_fire) begin
          if (q_inside) count_d = count_q + CW'(1);
          // The cursor never passes xmax/ymax, so no wrap handling is needed.
          if (at_last) begin
            state_d = DONE;
          end else if (cur_x_q == xmax_q) begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + W'(1);
          end else begin
            cur_x_d = cur_x_q + W'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The query port and payload follow the cursor, which only moves in BBOX
  // and on accepted beats, so they hold during stalls and outside SCAN.
  assign q_px         = cur_x_q;
  assign q_py         = cur_y_q;
  assign out_x        = cur_x_q;
  assign out_y        = cur_y_q;
  assign inside_count = count_q;
  assign state_dbg    = state_q;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_triangle_scanner.sv
// Bench for triangle_scanner: table of triangles with hand-computed boxes and
// inside counts, plus hand-written reset-mid-scan and back-to-back sequences.
module tb_triangle_scanner;

  localparam int W  = 12;
  localparam int CW = 2*W+1;

  logic          clk;
  logic          rst_n;
  logic          tri_valid;
  logic          tri_ready;
  logic [W-1:0]  ax, ay, bx, by, cx, cy;
  logic [W-1:0]  q_px, q_py;
  logic          q_inside;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_x, out_y;
  logic          out_inside;
  logic          out_last;
  logic          done;
  logic [CW-1:0] inside_count;
  logic [1:0]    state_dbg;

  triangle_scanner #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .q_px(q_px), .q_py(q_py), .q_inside(q_inside),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_inside(out_inside),
    .out_last(out_last), .done(done),
    .inside_count(inside_count), .state_dbg(state_dbg)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ax, ay, bx, by, cx, cy;
    int           mode;
    int           xmin, xmax, ymin, ymax;
    int           exp_count;
    bit           stall;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          q_mode   = 0;
  logic [25:0] exp_q[$];
  vec_t        vecs[6];

  // Evaluator stand-in: 0 = right triangle x+y<=4, 1 = odd x+y, else always in.
  function automatic logic model_inside(input int mode, input int x, input int y);
    case (mode)
      0:       return ((x + y) <= 4);
      1:       return (((x + y) % 2) == 1);
      default: return 1'b1;
    endcase
  endfunction

  always_comb q_inside = model_inside(q_mode, int'(q_px), int'(q_py));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_tri(input vec_t v);
    ax = v.ax; ay = v.ay; bx = v.bx; by = v.by; cx = v.cx; cy = v.cy;
  endtask

  // Waits (bounded) for tri_ready at a falling edge, then offers the triangle
  // and returns just after the accepting rising edge.
  task automatic accept_tri(input vec_t v);
    int n = 0;
    @(negedge clk);
    while (!tri_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tri_ready_wait", {31'd0, tri_ready}, 32'd1);
    drive_tri(v);
    tri_valid = 1'b1;
    @(posedge clk);
  endtask

  // Called right after an accept edge; checks every cycle up to one past done.
  task automatic monitor_scan(input vec_t v, input bit hold_valid, input vec_t nxt);
    int          k = 0;
    int          beats;
    int          stalls = 0;
    bit          got_done = 0;
    logic [25:0] act;
    q_mode = v.mode;
    exp_q.delete();
    for (int y = v.ymin; y <= v.ymax; y++)
      for (int x = v.xmin; x <= v.xmax; x++)
        exp_q.push_back({12'(x), 12'(y), model_inside(v.mode, x, y),
                         (x == v.xmax && y == v.ymax)});
    beats = exp_q.size();
    while (!got_done && k < 3000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("bbox_valid", {31'd0, out_valid}, 32'd0);
        check("bbox_tri_ready", {31'd0, tri_ready}, 32'd0);
        check("bbox_state", {30'd0, state_dbg}, 32'd1);
        check("bbox_count_clr", 32'(inside_count), 32'd0);
        if (hold_valid) drive_tri(nxt);
        else tri_valid = 1'b0;
        out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (exp_q.size() > 0) begin
        out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        check("scan_valid", {31'd0, out_valid}, 32'd1);
        check("scan_done_low", {31'd0, done}, 32'd0);
        check("scan_tri_ready", {31'd0, tri_ready}, 32'd0);
        check("scan_query", {8'd0, q_px, q_py}, {8'd0, exp_q[0][25:2]});
        act = {out_x, out_y, out_inside, out_last};
        check("beat", {6'd0, act}, {6'd0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
        else stalls++;
      end else begin
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_cycle", k, 2 + beats + stalls);
        check("done_valid_low", {31'd0, out_valid}, 32'd0);
        check("done_count", 32'(inside_count), v.exp_count);
        got_done = 1;
      end
    end
    check("scan_finished", {31'd0, got_done}, 32'd1);
    @(negedge clk);
    check("idle_tri_ready", {31'd0, tri_ready}, 32'd1);
    check("idle_done_low", {31'd0, done}, 32'd0);
    check("idle_count_hold", 32'(inside_count), v.exp_count);
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    bit hit;
    vecs[0] = '{12'd0, 12'd0, 12'd4, 12'd0, 12'd0, 12'd4, 0, 0, 4, 0, 4, 15, 1'b0};
    vecs[1] = '{12'd0, 12'd0, 12'd4, 12'd0, 12'd0, 12'd4, 0, 0, 4, 0, 4, 15, 1'b1};
    vecs[2] = '{12'd100, 12'd200, 12'd100, 12'd200, 12'd100, 12'd200, 2,
                100, 100, 200, 200, 1, 1'b0};
    vecs[3] = '{12'd4095, 12'd10, 12'd4093, 12'd12, 12'd4094, 12'd10, 1,
                4093, 4095, 10, 12, 5, 1'b1};
    vecs[4] = '{12'd0, 12'd4, 12'd0, 12'd0, 12'd4, 12'd0, 0, 0, 4, 0, 4, 15, 1'b1};
    vecs[5] = '{12'd3, 12'd7, 12'd1, 12'd7, 12'd2, 12'd7, 0, 1, 3, 7, 7, 0, 1'b0};

    rst_n = 1'b0; tri_valid = 1'b0; out_ready = 1'b0;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
    repeat (3) @(negedge clk);
    check("rst_tri_ready", {31'd0, tri_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_count", 32'(inside_count), 32'd0);
    check("rst_query", {8'd0, q_px, q_py}, 32'd0);
    check("rst_payload", {7'd0, out_x, out_y, out_inside}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      accept_tri(vecs[i]);
      monitor_scan(vecs[i], 1'b0, vecs[i]);
    end

    // Reset during the 7th beat of the right triangle.
    q_mode = 0;
    accept_tri(vecs[0]);
    out_ready = 1'b1;
    n = 0; hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      tri_valid = 1'b0;
      if (out_valid) begin
        if (n == 6) begin
          rst_n = 1'b0;
          hit = 1;
        end
        n++;
      end
    end
    check("rst_mid_reached", {31'd0, hit}, 32'd1);
    @(negedge clk);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_tri_ready", {31'd0, tri_ready}, 32'd1);
    check("rst_mid_count", 32'(inside_count), 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_no_done", {31'd0, done}, 32'd0);
    check("rst_mid_idle_valid", {31'd0, out_valid}, 32'd0);
    accept_tri(vecs[3]);
    monitor_scan(vecs[3], 1'b0, vecs[3]);

    // Back-to-back: tri_valid stays high, second triangle waits in the inputs.
    accept_tri(vecs[2]);
    monitor_scan(vecs[2], 1'b1, vecs[0]);
    @(posedge clk);
    monitor_scan(vecs[0], 1'b0, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/triangle_scanner.md
# triangle_scanner

Sequential point generator that sits in front of the `isInTriangle` point-in-triangle evaluator. It accepts one triangle (three 12-bit vertices) per handshake, computes its bounding box, and walks every integer point of that box in raster order. For each point it drives the evaluator's query port and streams the point plus the evaluator's verdict out on a valid/ready interface. It replaces file-driven stimulus with on-chip scan generation and result collection.

## Interface
- `W`, 12: coordinate width (unsigned).
- `CW`, 2*W+1 (25): inside-count width; holds a full 4096x4096 box.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tri_valid`  in  1  triangle offered.
- `tri_ready`  out  1  scanner can accept a triangle.
- `ax, ay, bx, by, cx, cy`  in  W each  vertices, sampled on accept.
- `q_px, q_py`  out  W each  query point to `isInTriangle`.
- `q_inside`  in  1  combinational verdict from `isInTriangle` for `q_px, q_py`.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  consumer accepts beat.
- `out_x, out_y`  out  W each  point of current beat.
- `out_inside`  out  1  verdict for current beat.
- `out_last`  out  1  final point of the bounding box.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `inside_count`  out  CW  number of accepted beats with `out_inside=1` for the current/last triangle.

## Operation
- States: IDLE, BBOX, SCAN, DONE.
- IDLE:
  - `tri_ready=1`.
  - On `tri_valid & tri_ready`: latch all six vertices, clear `inside_count`, go to BBOX.
- BBOX (exactly 1 cycle):
  - Register `xmin/xmax/ymin/ymax` as the unsigned min/max of the three x and three y values.
  - Set `cur_x=xmin`, `cur_y=ymin`; go to SCAN.
- SCAN:
  - `q_px=cur_x`, `q_py=cur_y`.
  - `out_valid=1`, `out_x=cur_x`, `out_y=cur_y`, `out_inside=q_inside`.
  - `out_last=(cur_x==xmax && cur_y==ymax)`.
- Beat accepted (`out_valid & out_ready`):
  - If `out_inside`, increment `inside_count`.
  - If `out_last`, go to DONE.
  - Else if `cur_x==xmax`: set `cur_x=xmin`, `cur_y=cur_y+1`.
  - Else: `cur_x=cur_x+1`.
- Backpressure: while `out_ready=0`, `cur_x/cur_y` and all output payload hold stable; `out_valid` never drops before acceptance.
- DONE (exactly 1 cycle): `done=1`; go to IDLE. `inside_count` holds until the next triangle accept.
- Comparisons and counters are unsigned. `cur_x/cur_y` never exceed `xmax/ymax`, so there is no wrap at 4095.
- Degenerate triangles:
  - Collinear or all-equal vertices are scanned normally.
  - A single-point box yields one beat with `out_last=1`.
- `tri_valid` outside IDLE is ignored (`tri_ready=0`).

## Timing
- Reset (`rst_n=0` at a rising edge), from any state, mid-scan included:
  - state=IDLE.
  - `tri_ready=1`, `out_valid=0`, `out_last=0`, `done=0`.
  - `inside_count=0`, `q_px=q_py=0`, `out_x=out_y=0`, `out_inside=0`.
  - Any scan in progress is abandoned; no `done` pulse.
- Accept edge N:
  - BBOX during cycle N+1.
  - First `out_valid` in cycle N+2.
- With `out_ready` held high, one beat per cycle. For a box of Wb x Hb points:
  - Last beat in cycle N+1+Wb*Hb.
  - `done` in the following cycle.
  - `tri_ready` high again the cycle after `done`.
- `q_inside` is sampled combinationally within the same cycle. `isInTriangle` must settle within one clock.
- Outside SCAN: `out_valid=0`, `out_last=0`, `q_px/q_py` hold their last value.

## Test plan
- **Right triangle, no stall.** A(0,0) B(4,0) C(0,4); bench models `q_inside=(px+py<=4)`; `out_ready=1`.
  - Expect 25 beats in order (0,0),(1,0)..(4,0),(0,1)..(4,4), one per cycle.
  - `out_last` only on (4,4); `done` next cycle; `inside_count=15`.
- **Random backpressure.** Same triangle, `out_ready` toggled pseudo-randomly.
  - Payload is stable across every stall; beat sequence and `inside_count=15` are unchanged.
  - Total cycles = 27 + stall cycles.
- **Degenerate point.** A=B=C=(100,200).
  - Exactly one beat (100,200) with `out_last=1`; `done` 3 cycles after accept.
- **Unsorted vertices at the top edge.** A(4095,10) B(4093,12) C(4094,10).
  - Box x 4093..4095, y 10..12; 9 beats, no coordinate wrap; last beat (4095,12).
- **Reset mid-scan.** Start the right triangle; assert `rst_n=0` during the 7th beat.
  - Next cycle: `out_valid=0`, `tri_ready=1`, `inside_count=0`, no `done`.
  - A new triangle then scans from its own `xmin/ymin`.
- **Back-to-back triangles.** `tri_valid` held high with two triangles queued.
  - Second accept occurs the cycle after `done`.
  - `inside_count` is cleared on that accept, and holds the first triangle's value until then.
